vga_stream_tx: RTL
==================

// Module: vga_stream_tx
// PURPOSE
//  Video transmitter: pulls a 3-bit pixel stream through a valid/ready input and drives hsync/vsync/rgb.
//  It is the producing end of the capture log that dumps hsync/vsync/rgb as text frames.
//  Replays prerecorded or bench-generated frames into the same display interface that the game wrappers drive.
//  Includes an internal pixel FIFO, free-running H/V timing, and frame alignment on a start-of-frame marker.
// PARAMETERS
//  H_VIS 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch
//  V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (all in pixel/line units)
//  CLK_DIV 2 clocks per pixel (>=1); FIFO_DEPTH 16 pixel FIFO entries (power of 2, >=2)
// PORTS
//  clk         in  1  system clock
//  resetn      in  1  asynchronous reset, active-low
//  px_data     in  3  pixel colour {r,g,b}
//  px_sof      in  1  marks first pixel of a frame
//  px_valid    in  1  input word valid
//  px_ready    out 1  FIFO not full; word accepted when px_valid&&px_ready
//  hsync       out 1  horizontal sync, active-low pulse
//  vsync       out 1  vertical sync, active-low pulse
//  rgb         out 3  pixel colour; 0 outside visible area
//  frame_start out 1  1-clk pulse with first visible pixel of each frame
//  underflow   out 1  1-clk pulse: visible pixel needed, FIFO empty
//  sof_err     out 1  1-clk pulse: frame misalignment detected
// BEHAVIOUR
//  Reset: hsync=1 vsync=1 rgb=0 frame_start=underflow=sof_err=0; FIFO empty; counters 0; state WAIT_SOF.
//  Pixel tick every CLK_DIV clocks (divider counter 0..CLK_DIV-1, tick at 0). The first tick is the first clock after reset release.
//  hcnt 0..H_TOT-1 with H_TOT=H_VIS+H_FP+H_SYNC+H_BP, advancing on each tick. vcnt advances when hcnt wraps, over 0..V_TOT-1.
//  Visible: hcnt<H_VIS && vcnt<V_VIS.
//  hsync=0 when hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC). vsync is decoded the same way on vcnt.
//  Outputs are registered and update on tick clocks only, holding between ticks. Latency: 1 clk from the tick to the output.
//  rgb, hsync, vsync, frame_start and underflow are mutually aligned.
//  FIFO: push on px_valid&&px_ready. A simultaneous push and pop when full is not allowed, because ready is low.
//  A simultaneous push and pop when empty does not bypass; the pop sees empty.
//  States:
//   WAIT_SOF: rgb=0. On each clk, if the FIFO head has sof=0, pop and discard it.
//    At a tick with hcnt=0 and vcnt=0, if the head has sof=1 -> RUN (this pixel is the first one of the frame).
//   RUN: each visible tick pops one word and drives rgb=data.
//    If the FIFO is empty: rgb=0, underflow=1, no pop, stay RUN (pixel slips).
//    Head sof=1 at a visible tick other than (0,0): sof_err=1, rgb=0, no pop -> WAIT_SOF.
//    Head sof=0 at tick (0,0): sof_err=1, rgb=0 -> WAIT_SOF (it is discarded there).
//  frame_start=1 at tick (0,0) only when transitioning/staying in RUN with a valid sof pixel.
//  Non-visible ticks never pop. Asserting resetn mid-frame aborts immediately and clears all state.
// CONFIGURATION
//  VGA_STREAM_TX_PATTERN_EN: defined -> in WAIT_SOF, visible pixels show colour bars,
//   rgb = hcnt[5:3] (8 bars of 8 pixels), and underflow pixels show 3'b111.
//  Undefined -> both cases output 0 (rgb=0).
//  No other behaviour changes.
// STRUCTURE
//  vga_tx_pkg: state enum {WAIT_SOF,RUN}, pixel struct {sof,data[2:0]}, default timing localparams.
//  Sub-module vga_px_fifo: sync FIFO of the pixel struct with full/empty/head (show-ahead) and async active-low reset.
// TESTING (small config: H 8/2/2/2 => H_TOT=14, V 4/1/1/1 => V_TOT=7, CLK_DIV=2, FIFO_DEPTH=16)
//  Reset, no input -> hsync pulses low 2 ticks (4 clk) every 28 clk; vsync low for 1 line per 196 clk; rgb=0.
//  Preload 32 px with sof on the first, data=i%8 -> frame_start at (0,0); rgb sequence 0..7 per line;
//   px_ready stays high once space frees.
//  Stop input after 10 px of a frame -> underflow pulses for px 11..32, rgb=0; state stays RUN.
//  Send 3 px with sof=0 and then a sof frame -> the 3 px are discarded and output aligns at the next (0,0).
//  Send a sof at the 5th pixel of a running frame -> sof_err at that tick, blank until next (0,0),
//   then that frame plays.
//  resetn low mid-line for 1 clk -> outputs return to reset values; FIFO is emptied.
//  PATTERN_EN build: idle -> rgb = hcnt[5:3] on visible ticks.

Source files
------------

// File: rtl/vga_tx_pkg.sv
// Shared types and default timing for the VGA stream transmitter.
// Pixel payload, FSM state encoding and a sync-window decode helper.
package vga_tx_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  typedef struct packed {
    logic       sof;
    logic [2:0] data;
  } pixel_t;

  localparam int unsigned DEF_H_VIS      = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_VIS      = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  // True while cnt lies inside the sync pulse window [lo, lo+len).
  function automatic logic in_window(input int unsigned cnt, input int unsigned lo,
                                     input int unsigned len);
    return (cnt >= lo) && (cnt < lo + len);
  endfunction

endpackage

// File: rtl/vga_px_fifo.sv
// Show-ahead synchronous pixel FIFO; head is valid whenever empty is low.
// A pop on an empty FIFO is ignored even if a push lands on the same clock.
module vga_px_fifo
  import vga_tx_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  pixel_t wdata,
  input  logic   pop,
  output pixel_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  pixel_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vga_stream_tx.sv
// VGA transmitter: FIFO-buffered pixel stream aligned to frame start, free-running H/V timing.
// Build option VGA_STREAM_TX_PATTERN_EN: colour bars while unaligned, white on underflow.
module vga_stream_tx
  import vga_tx_pkg::*;
#(
  parameter int unsigned H_VIS      = DEF_H_VIS,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_VIS      = DEF_V_VIS,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] px_data,
  input  logic       px_sof,
  input  logic       px_valid,
  output logic       px_ready,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_start,
  output logic       underflow,
  output logic       sof_err
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = ($clog2(H_TOT) < 6) ? 6 : $clog2(H_TOT);
  localparam int unsigned VW    = ($clog2(V_TOT) < 1) ? 1 : $clog2(V_TOT);
  localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  state_t        state;
  state_t        state_nxt;
  pixel_t        head;
  pixel_t        wdata;
  logic          full;
  logic          empty;
  logic          pop_c;
  logic          tick_c;
  logic          vis_c;
  logic          origin_c;
  logic [2:0]    idle_rgb_c;
  logic [2:0]    uf_rgb_c;
  logic [2:0]    rgb_nxt;
  logic          fs_nxt;
  logic          uf_nxt;
  logic          se_nxt;

  assign wdata    = '{sof: px_sof, data: px_data};
  assign px_ready = !full;
  assign tick_c   = (div == '0);
  assign vis_c    = (hcnt < HW'(H_VIS)) && (vcnt < VW'(V_VIS));
  assign origin_c = (hcnt == '0) && (vcnt == '0);

`ifdef VGA_STREAM_TX_PATTERN_EN
  assign idle_rgb_c = vis_c ? hcnt[5:3] : 3'b000;
  assign uf_rgb_c   = 3'b111;
`else
  assign idle_rgb_c = 3'b000;
  assign uf_rgb_c   = 3'b000;
`endif

  vga_px_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (px_valid),
    .wdata (wdata),
    .pop   (pop_c),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Pixel divider and raster counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= (div == DW'(CLK_DIV - 1)) ? '0 : div + DW'(1);
      if (tick_c) begin
        if (hcnt == HW'(H_TOT - 1)) begin
          hcnt <= '0;
          vcnt <= (vcnt == VW'(V_TOT - 1)) ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  // Frame alignment: pop/colour/flag decisions for the current clock.
  always_comb begin
    pop_c     = 1'b0;
    state_nxt = state;
    rgb_nxt   = 3'b000;
    fs_nxt    = 1'b0;
    uf_nxt    = 1'b0;
    se_nxt    = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (!empty && !head.sof) pop_c = 1'b1;
        if (tick_c) begin
          rgb_nxt = idle_rgb_c;
          if (origin_c && !empty && head.sof) begin
            pop_c     = 1'b1;
            rgb_nxt   = head.data;
            fs_nxt    = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (tick_c && vis_c) begin
          if (empty) begin
            uf_nxt  = 1'b1;
            rgb_nxt = uf_rgb_c;
          end else if (head.sof != origin_c) begin
            // Early sof is kept for the next frame; a late one is flushed in WAIT_SOF.
            se_nxt    = 1'b1;
            state_nxt = WAIT_SOF;
          end else begin
            pop_c   = 1'b1;
            rgb_nxt = head.data;
            fs_nxt  = origin_c;
          end
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  // State and registered outputs; video outputs change on ticks only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= WAIT_SOF;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 3'b000;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_start <= fs_nxt;
      underflow   <= uf_nxt;
      sof_err     <= se_nxt;
      if (tick_c) begin
        rgb   <= rgb_nxt;
        hsync <= !in_window(32'(hcnt), H_VIS + H_FP, H_SYNC);
        vsync <= !in_window(32'(vcnt), V_VIS + V_FP, V_SYNC);
      end
    end
  end

endmodule
